// File: rtl/multdiv_sequencer_if.sv
// Start/operand/status bundle between the multicycle control unit and the
// multiply/divide sequencer.
interface multdiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic             MultCtrl;
  logic             DivCtrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             MultOut;
  logic             DivOut;
  logic             divZero;
  logic             HILOWrite;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  // Control unit side
  modport master (
    output MultCtrl, DivCtrl, op_a, op_b,
    input  busy, MultOut, DivOut, divZero, HILOWrite, HI, LO
  );

  // Sequencer side
  modport slave (
    input  MultCtrl, DivCtrl, op_a, op_b,
    output busy, MultOut, DivOut, divZero, HILOWrite, HI, LO
  );

endinterface

// File: rtl/multdiv_sequencer.sv
// Iterative signed shift-add multiply / restoring divide owning HI/LO.
// Define MULTDIV_EARLY_EXIT_EN to end a multiply once the multiplier drains to zero.
module multdiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multdiv_sequencer_if.slave    bus
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_mult;
  logic             sign_a;
  logic             sign_b;

  logic [DW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [DW-1:0]    prod;

  // quo starts as the dividend magnitude; quotient bits shift in as its MSBs leave
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;

  logic             busy_q;
  logic             mult_out_q;
  logic             div_out_q;
  logic             div_zero_q;
  logic             hilo_write_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [DW-1:0]    prod_next;
  logic [WIDTH:0]   rem_shift;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [DW-1:0]    mult_res;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;
  logic             mult_last;

  // Operand magnitudes; the most negative value maps onto itself as unsigned
  always_comb begin
    abs_a = bus.op_a[WIDTH-1] ? WIDTH'(-bus.op_a) : bus.op_a;
    abs_b = bus.op_b[WIDTH-1] ? WIDTH'(-bus.op_b) : bus.op_b;
  end

  // One multiply step and one restoring-divide step
  always_comb begin
    prod_next = mplier[0] ? DW'(prod + mcand) : prod;
    rem_shift = {rem, quo[WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, dvs});
    rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, dvs}) : WIDTH'(rem_shift);
  end

  // Sign correction applied when HI/LO are loaded
  always_comb begin
    mult_res = (sign_a ^ sign_b) ? DW'(-prod) : prod;
    quo_res  = (sign_a ^ sign_b) ? WIDTH'(-quo) : quo;
    rem_res  = sign_a ? WIDTH'(-rem) : rem;
  end

`ifdef MULTDIV_EARLY_EXIT_EN
  // Done once the shifted multiplier holds no more set bits
  always_comb begin
    mult_last = (cnt == LAST_ITER) || (mplier[WIDTH-1:1] == '0);
  end
`else
  always_comb begin
    mult_last = (cnt == LAST_ITER);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      op_mult      <= 1'b0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      mcand        <= '0;
      mplier       <= '0;
      prod         <= '0;
      quo          <= '0;
      dvs          <= '0;
      rem          <= '0;
      busy_q       <= 1'b0;
      mult_out_q   <= 1'b0;
      div_out_q    <= 1'b0;
      div_zero_q   <= 1'b0;
      hilo_write_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      mult_out_q   <= 1'b0;
      div_out_q    <= 1'b0;
      div_zero_q   <= 1'b0;
      hilo_write_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.MultCtrl) begin
            sign_a  <= bus.op_a[WIDTH-1];
            sign_b  <= bus.op_b[WIDTH-1];
            mcand   <= DW'(abs_a);
            mplier  <= abs_b;
            prod    <= '0;
            op_mult <= 1'b1;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= MULT_RUN;
          end else if (bus.DivCtrl) begin
            // Zero divisor is reported immediately and never enters DIV_RUN
            if (bus.op_b == '0) begin
              div_zero_q <= 1'b1;
            end else begin
              sign_a  <= bus.op_a[WIDTH-1];
              sign_b  <= bus.op_b[WIDTH-1];
              quo     <= abs_a;
              dvs     <= abs_b;
              rem     <= '0;
              op_mult <= 1'b0;
              cnt     <= '0;
              busy_q  <= 1'b1;
              state   <= DIV_RUN;
            end
          end
        end

        MULT_RUN: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (mult_last) state <= FINISH;
        end

        DIV_RUN: begin
          rem <= rem_next;
          quo <= {quo[WIDTH-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) state <= FINISH;
        end

        FINISH: begin
          if (op_mult) begin
            hi_q       <= mult_res[DW-1:WIDTH];
            lo_q       <= mult_res[WIDTH-1:0];
            mult_out_q <= 1'b1;
          end else begin
            hi_q      <= rem_res;
            lo_q      <= quo_res;
            div_out_q <= 1'b1;
          end
          hilo_write_q <= 1'b1;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.MultOut   = mult_out_q;
  assign bus.DivOut    = div_out_q;
  assign bus.divZero   = div_zero_q;
  assign bus.HILOWrite = hilo_write_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: latency, signed results, divide by zero,
// start priority, mid-operation reset and overflow corners.
module tb_multdiv_sequencer;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multdiv_sequencer_if #(.WIDTH(W)) bus ();

  multdiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from start edge to visible done pulse for a multiply by b
  function automatic int mult_lat(input logic [31:0] b);
    logic [31:0] m;
    int it;
    m  = b[31] ? -b : b;
    it = 1;
    for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
`ifndef MULTDIV_EARLY_EXIT_EN
    it = 32;
`endif
    return it + 1;
  endfunction

  // Launch one operation in the current cycle and follow it to its done pulse
  task automatic run_op(input string tag, input bit is_mult, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat);
    int n;
    int busy_n;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.MultCtrl = is_mult;
    bus.DivCtrl  = !is_mult;
    tick();
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = b ^ 32'h5A5A_0001;
    chk({tag, " busy_at_start"}, 64'(bus.busy), 64'd1);
    chk({tag, " prior_pulses_clear"},
        64'({bus.MultOut, bus.DivOut, bus.HILOWrite, bus.divZero}), 64'd0);
    n      = 0;
    busy_n = 1;
    while (!(bus.MultOut || bus.DivOut) && n < 100) begin
      tick();
      n++;
      if (bus.busy) busy_n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    chk({tag, " done_kind"}, 64'({bus.MultOut, bus.DivOut}), is_mult ? 64'd2 : 64'd1);
    chk({tag, " hilowrite"}, 64'({bus.HILOWrite, bus.busy, bus.divZero}), 64'b100);
    chk({tag, " HI"}, 64'(bus.HI), 64'(exp_hi));
    chk({tag, " LO"}, 64'(bus.LO), 64'(exp_lo));
  endtask

  initial begin : stim
    int done_cnt;
    int done_at;
    int stray;
    int lat;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo;

    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    reset        = 1'b0;
    repeat (3) tick();
    chk("reset outputs",
        64'({bus.busy, bus.MultOut, bus.DivOut, bus.divZero, bus.HILOWrite}), 64'd0);
    chk("reset HI", 64'(bus.HI), 64'd0);
    chk("reset LO", 64'(bus.LO), 64'd0);
    reset = 1'b1;
    tick();

    // 3 * -5
    run_op("mul_3_m5", 1'b1, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
           mult_lat(32'hFFFF_FFFB));

    // Signed divides, second started during the first's done cycle
    run_op("div_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
    run_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);

    // Preload HI=1, LO=2, then divide by zero
    run_op("preload_5_2", 1'b0, 32'd5, 32'd2, 32'd1, 32'd2, 33);
    bus.op_a    = 32'd5;
    bus.op_b    = 32'd0;
    bus.DivCtrl = 1'b1;
    tick();
    bus.DivCtrl = 1'b0;
    chk("divzero pulse", 64'(bus.divZero), 64'd1);
    chk("divzero no_busy_done",
        64'({bus.busy, bus.DivOut, bus.MultOut, bus.HILOWrite}), 64'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.busy || bus.DivOut || bus.HILOWrite || bus.divZero) stray++;
    end
    chk("divzero quiet_after", 64'(stray), 64'd0);
    chk("divzero HI kept", 64'(bus.HI), 64'd1);
    chk("divzero LO kept", 64'(bus.LO), 64'd2);

    // Simultaneous requests: multiply wins; stray DivCtrl while busy ignored
    lat          = mult_lat(32'd7);
    bus.op_a     = 32'd6;
    bus.op_b     = 32'd7;
    bus.MultCtrl = 1'b1;
    bus.DivCtrl  = 1'b1;
    tick();
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    chk("both busy", 64'(bus.busy), 64'd1);
    done_cnt = 0;
    done_at  = 0;
    stray    = 0;
    cap_hi   = '1;
    cap_lo   = '1;
    for (int i = 1; i <= 80; i++) begin
      bus.DivCtrl = (i < lat) && (i == 2 || i == 10);
      tick();
      if (bus.MultOut) begin
        done_cnt++;
        done_at = i;
        cap_hi  = bus.HI;
        cap_lo  = bus.LO;
      end
      if (bus.DivOut || bus.divZero) stray++;
    end
    bus.DivCtrl = 1'b0;
    chk("both single_done", 64'(done_cnt), 64'd1);
    chk("both latency", 64'(done_at), 64'(lat));
    chk("both no_div", 64'(stray), 64'd0);
    chk("both HI", 64'(cap_hi), 64'd0);
    chk("both LO", 64'(cap_lo), 64'd42);

    // Reset at iteration 10 of a divide
    bus.op_a    = 32'd100;
    bus.op_b    = 32'd7;
    bus.DivCtrl = 1'b1;
    tick();
    bus.DivCtrl = 1'b0;
    repeat (10) tick();
    chk("midreset busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midreset flags",
        64'({bus.busy, bus.MultOut, bus.DivOut, bus.HILOWrite, bus.divZero}), 64'd0);
    chk("midreset HI", 64'(bus.HI), 64'd0);
    chk("midreset LO", 64'(bus.LO), 64'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.busy || bus.DivOut || bus.MultOut || bus.HILOWrite) stray++;
    end
    chk("midreset no_done", 64'(stray), 64'd0);
    run_op("after_reset_mul", 1'b1, 32'd6, 32'd7, 32'd0, 32'd42, mult_lat(32'd7));

    // Overflow and magnitude corners
    run_op("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    run_op("mul_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,
           mult_lat(32'h8000_0000));
    run_op("mul_5_3", 1'b1, 32'd5, 32'd3, 32'd0, 32'd15, mult_lat(32'd3));
    run_op("mul_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1,
           mult_lat(32'hFFFF_FFFF));
    run_op("div_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Iterative signed multiply/divide engine with its own sequencing FSM.
- Takes the MultCtrl/DivCtrl start requests from the multicycle control unit and runs a 32-iteration shift-add multiply or restoring divide on rs/rt operands.
- Returns one-cycle MultOut/DivOut/divZero status to the control unit.
- Owns the HI/LO registers read by mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI/LO width; base iteration count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- MultCtrl  in  1  multiply start request, sampled only in IDLE.
- DivCtrl  in  1  divide start request, sampled only in IDLE.
- op_a  in  WIDTH  rs operand: multiplicand or dividend.
- op_b  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  operation in progress.
- MultOut  out  1  one-cycle pulse, multiply done.
- DivOut  out  1  one-cycle pulse, divide done.
- divZero  out  1  one-cycle pulse, divide by zero.
- HILOWrite  out  1  one-cycle pulse, HI/LO updated.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset: when reset==0 at a clk edge, regardless of state:
  - state <= IDLE.
  - HI, LO, busy, MultOut, DivOut, divZero, HILOWrite and internal counters/accumulators <= 0.
  - An operation in flight is discarded; no done pulse is produced.
- States: IDLE, MULT_RUN, DIV_RUN, FINISH.
- Start (edge E0, state IDLE):
  - Start priority: MultCtrl > DivCtrl. If both are high, the multiply runs and the divide is dropped silently.
  - At E0, latch |op_a|, |op_b|, sign_a, sign_b; set busy=1 and iteration counter=0.
  - Requests while busy, or while in FINISH, are ignored.
- Multiply (MULT_RUN):
  - Per cycle: if mplier[0], prod += mcand; then mcand <<= 1, mplier >>= 1, counter++.
  - mcand and prod are 2*WIDTH bits.
  - After WIDTH iterations (E1..E32), go to FINISH.
- Divide (DIV_RUN):
  - Restoring algorithm on magnitudes, one quotient bit per cycle, MSB first.
  - rem = {rem, dividend_msb}; if rem >= divisor, rem -= divisor and qbit = 1.
  - After WIDTH iterations, go to FINISH.
- FINISH (edge E33):
  - Apply sign correction and load HI/LO.
  - Mult: {HI,LO} = sign_a^sign_b ? -prod : prod.
  - Div: LO = quotient negated if sign_a^sign_b; HI = remainder negated if sign_a (remainder takes the dividend's sign).
  - At the same edge: busy <= 0; MultOut or DivOut <= 1; HILOWrite <= 1 for exactly one cycle; state <= IDLE.
- Latency:
  - Done pulse is visible in the cycle after E33, i.e. 33 cycles after the start edge.
  - HI/LO are already valid in that same cycle.
  - A new start is accepted during the done-pulse cycle.
- Divide by zero:
  - op_b==0 with DivCtrl at E0: no DIV_RUN.
  - At E0, divZero <= 1 for one cycle and state stays IDLE.
  - busy remains 0; HI/LO are unchanged; no DivOut or HILOWrite.
- Overflow:
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 (magnitude wrap). No exception.
  - Multiply never overflows (full 64-bit result).
- Operands are sampled only at E0; changes during RUN have no effect.

Optional Feature:
- MULTDIV_EARLY_EXIT_EN
- Defined: MULT_RUN exits to FINISH as soon as the mplier register becomes 0, after at least one iteration.
  - Iteration count = max(1, index of highest set bit of |op_b| + 1).
  - The done pulse moves earlier by the same amount.
  - Divide latency is unchanged.
- Undefined: multiply always takes WIDTH iterations (fixed 33-cycle latency).

Test Plan:
1. MultCtrl, op_a=3, op_b=0xFFFFFFFB (-5) -> busy high 33 cycles; MultOut+HILOWrite pulse at cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
2. DivCtrl 7 / -2 -> LO=0xFFFFFFFD, HI=1. Then -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DivOut at cycle 33 each time.
3. Preload HI=1, LO=2, then DivCtrl 5 / 0 -> divZero pulse in cycle 1; busy never set; HI=1, LO=2; no DivOut.
4. MultCtrl and DivCtrl in the same cycle with 6 and 7 -> multiply only (LO=42, HI=0); extra DivCtrl pulses at cycle 10 are ignored; only one done pulse.
5. reset=0 at iteration 10 of a divide -> next cycle state IDLE, busy=0, HI=LO=0, no done pulse; a fresh MultCtrl then completes normally.
6. 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0. With MULTDIV_EARLY_EXIT_EN, 5*3 finishes after 2 iterations (done 3 cycles after start).
